tile_mem_writer: RTL

TILE_MEM_WRITER -- requirements
Module: tile_mem_writer

---
 rtl/tile_mem_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tile_mem_writer.sv
// tile_mem_writer
//   Accepts a stream of 12-bit RGB pixels for one TILE_W x TILE_H tile and
//   writes them, in raster order, into a word-addressed pixel memory that
//   uses the same addressing as the display read path:
//     addr = (BASE_ADDR + x + y*TILE_W) mod 2^17
//
//   A tile starts with a beat flagged by pix_sof. After the last pixel has
//   been accepted, the block spends one cycle in DONE (pix_ready low,
//   frame_done high) and then returns to IDLE for the next tile.
//
// Optional feature (compile-time macro TILE_WR_SOF_RESYNC_EN):
//   defined   : a pix_sof beat in the middle of a tile restarts the tile at
//               (0,0) and pulses sof_err alongside that beat's write.
//   undefined : pix_sof is ignored mid-tile and sof_err is always 0.
//
// Parameters:
//   TILE_W     tile width in pixels (power of two, 1..256)
//   TILE_H     tile height in rows (1..256)
//   BASE_ADDR  17-bit word address of pixel (0,0)
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   synchronous reset, active low
//   pix_valid   in   upstream beat present
//   pix_sof     in   beat is the first pixel of a tile
//   pix_data    in   {R[3:0],G[3:0],B[3:0]}
//   pix_ready   out  beat accepted this cycle (function of FSM state only)
//   wr_en       out  one-cycle memory write strobe (registered)
//   wr_addr     out  memory write address (registered, holds when idle)
//   wr_data     out  memory write data (registered, holds when idle)
//   frame_done  out  high during the single DONE cycle after a tile
//   sof_err     out  pulse with the write of a mid-tile pix_sof beat
//
// Handshake: a beat transfers on a rising edge where pix_valid=1 and
// pix_ready=1. pix_valid may drop at any time; the block simply waits.
// Its write appears on wr_en/wr_addr/wr_data in the following cycle.
//
// The internal signal 'state' carries the FSM state for external checkers.

module tile_mem_writer #(
  parameter int          TILE_W    = 64,
  parameter int          TILE_H    = 64,
  parameter logic [16:0] BASE_ADDR = 17'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [11:0] pix_data,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        frame_done,
  output logic        sof_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [8:0]  x;
  logic [8:0]  y;
  logic        sof_err_q;

  logic        xfer;
  logic        accept;
  logic        resync_hit;
  logic [8:0]  cur_x;
  logic [8:0]  cur_y;
  logic [8:0]  nxt_x;
  logic [8:0]  nxt_y;
  logic        last_col;
  logic        last_row;
  logic        tile_end;
  logic [16:0] lin_addr;

  assign pix_ready = (state != DONE);
  assign xfer      = pix_valid & pix_ready;

`ifdef TILE_WR_SOF_RESYNC_EN
  assign resync_hit = (state == WRITE) && pix_sof;
`else
  assign resync_hit = 1'b0;
`endif

  // In IDLE only a start-of-tile beat is written; anything else is dropped.
  assign accept = xfer && ((state == WRITE) || pix_sof);

  // Position of the beat on the input this cycle: a tile start (first beat
  // or resync) always lands at (0,0), otherwise at the running counters.
  always_comb begin
    cur_x = x;
    cur_y = y;
    if (state == IDLE || resync_hit) begin
      cur_x = 9'd0;
      cur_y = 9'd0;
    end
  end

  assign last_col = (cur_x == 9'(TILE_W - 1));
  assign last_row = (cur_y == 9'(TILE_H - 1));
  assign tile_end = last_col && last_row;

  // Raster advance; after the final pixel both counters fall back to 0.
  always_comb begin
    nxt_x = cur_x + 9'd1;
    nxt_y = cur_y;
    if (last_col) begin
      nxt_x = 9'd0;
      nxt_y = last_row ? 9'd0 : (cur_y + 9'd1);
    end
  end

  // 17-bit arithmetic throughout so the address wraps modulo 2^17.
  assign lin_addr = BASE_ADDR + 17'(cur_x) + (17'(cur_y) * 17'(TILE_W));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= 9'd0;
      y          <= 9'd0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 12'd0;
      frame_done <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sof_err_q  <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (accept) begin
            wr_en     <= 1'b1;
            wr_addr   <= lin_addr;
            wr_data   <= pix_data;
            sof_err_q <= resync_hit;
            x         <= nxt_x;
            y         <= nxt_y;
            if (tile_end) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sof_err = sof_err_q;

endmodule
